// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency load/store handshake in front of an inferred word RAM.
// Optional store monitor (last_st_addr/last_st_data/st_count) enabled by DMEM_STORE_MONITOR_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        memwrite,
    input  logic [3:0]  byte_en,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        mem_ready,
    output logic        mem_stall,
    output logic        addr_err,
    output logic [31:0] last_st_addr,
    output logic [31:0] last_st_data,
    output logic [15:0] st_count
);
    localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [31:0] readdata_q, readdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic        enter_resp;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_we, cur_err;
    logic [AW-1:0] cur_idx;

    // With LATENCY=1 RESP is entered on the accepting edge, so the live inputs
    // stand in for the not-yet-captured request.
    always_comb begin
        cur_addr  = (state_q == IDLE) ? dataadr   : addr_q;
        cur_wdata = (state_q == IDLE) ? writedata : wdata_q;
        cur_be    = (state_q == IDLE) ? byte_en   : be_q;
        cur_we    = (state_q == IDLE) ? memwrite  : we_q;
        cur_idx   = cur_addr[AW+1:2];
        cur_err   = ((cur_addr[1:0] != 2'b00) && (cur_be == 4'hF)) ||
                    ({1'b0, cur_addr} >= BYTE_LIMIT);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        readdata_d = readdata_q;
        err_d      = err_q;
        ready_d    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    addr_d  = dataadr;
                    wdata_d = writedata;
                    be_d    = byte_en;
                    we_d    = memwrite;
                    cnt_d   = LAT_M1;
                    if (LAT_M1 == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            ready_d    = 1'b1;
            err_d      = cur_err;
            readdata_d = cur_err ? '0 : mem[cur_idx];
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            readdata_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            readdata_q <= readdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clka) begin
        if (!rst && enter_resp && cur_we && !cur_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign readdata  = readdata_q;
    assign mem_ready = ready_q;
    assign addr_err  = err_q;
    assign mem_stall = mem_en && (state_q != RESP);

`ifdef DMEM_STORE_MONITOR_EN
    logic [31:0] la_q, la_d, ld_q, ld_d;
    logic [15:0] sc_q, sc_d;

    always_comb begin
        la_d = la_q;
        ld_d = ld_q;
        sc_d = sc_q;
        if (enter_resp && cur_we && !cur_err && (cur_be != 4'h0)) begin
            la_d = cur_addr;
            ld_d = cur_wdata;
            if (sc_q != 16'hFFFF) sc_d = sc_q + 16'd1;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            la_q <= '0;
            ld_q <= '0;
            sc_q <= '0;
        end else begin
            la_q <= la_d;
            ld_q <= ld_d;
            sc_q <= sc_d;
        end
    end

    assign last_st_addr = la_q;
    assign last_st_data = ld_q;
    assign st_count     = sc_q;
`else
    assign last_st_addr = '0;
    assign last_st_data = '0;
    assign st_count     = '0;
`endif
endmodule
